if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Instruction-fetch stage directly downstream of PC_Update.
- Takes the current PC, issues one-outstanding requests to instruction memory, buffers the returned words in a small FIFO, and presents {pc, instr} to decode as the IF/ID register.
- Handles decode stalls, branch/JAL redirect flushes and variable-latency memory responses. While a redirect is pending, it discards any stale response.

Parameters:
- BUF_DEPTH, 2, instruction buffer entries (power of two, ≥2).
- NOP_INSTR, 32'h00000013, instruction presented when the output is invalid (addi x0,x0,0).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- pc_in  in  32  current PC from PC_Update.
- redirect  in  1  branch_taken | flag_jump; flushes the stage.
- pc_advance  out  1  PC_Update may step PC this cycle (a request was accepted).
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address (= pc_in).
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  32  response instruction.
- id_stall  in  1  decode cannot consume this cycle.
- id_valid  out  1  head entry valid.
- id_pc  out  32  PC of the head entry.
- id_instr  out  32  head instruction, or NOP_INSTR when id_valid=0.

Behaviour:
- Reset (async): FSM=IDLE, buffer empty, count=0, id_valid=0, id_pc=0, id_instr=NOP_INSTR, imem_req=0, pc_advance=0.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding.
  - DRAIN: one stale request outstanding whose response must be dropped.
- imem_req is combinational: asserted when FSM=IDLE, redirect=0 and count < BUF_DEPTH. imem_addr = pc_in.
- pc_advance = imem_req & imem_gnt.
- Transitions:
  - IDLE→WAIT on a grant.
  - WAIT→IDLE on rvalid; the response is written with its PC, captured at grant time into req_pc.
  - WAIT→DRAIN on redirect without rvalid.
  - WAIT with redirect and rvalid in the same cycle: the response is dropped, next state IDLE.
  - DRAIN→IDLE on rvalid; the data is discarded.
  - Redirect in DRAIN stays in DRAIN.
- Grant and response may not coincide for the same request. The minimum latency is one cycle after the grant.
- Buffer behaviour:
  - Circular FIFO with separate rd/wr pointers wrapping mod BUF_DEPTH.
  - Push on an accepted response. Pop when id_valid & ~id_stall.
  - Push and pop in the same cycle leave count unchanged.
  - The request guard (count < BUF_DEPTH in IDLE) ensures a response never arrives while the buffer is full.
- Outputs: id_valid = (count ≠ 0). id_pc/id_instr are driven from the head entry.
  - Fetch-to-decode latency: response cycle + 1. The entry is visible the cycle after rvalid.
- Redirect:
  - Synchronous flush: count←0 and pointers←0 next cycle, regardless of id_stall.
  - id_valid=0 and id_instr=NOP_INSTR from the next cycle.
  - No request is issued in the redirect cycle. Fetch resumes from the new pc_in the following cycle, or after DRAIN completes.
- Redirect and pop in the same cycle: the flush wins.
- Reset mid-request: the outstanding response is lost. The memory is also reset by the same reset.

Decomposition:
- Shared package riscv_pkg holds:
  - NOP_INSTR
  - XLEN=32
  - the fetch FSM state enum (IDLE/WAIT/DRAIN)
- One natural sub-module: if_fifo, a parameterised synchronous FIFO with push/pop/flush/count.
- The FSM and request logic live in the top level.

Test Plan:
1. Reset with pc_in=0x0, gnt always 1, rvalid 1 cycle after grant, id_stall=0 → id_valid rises with id_pc=0x0, then 0x4, 0x8 on consecutive response cycles; no NOP bubbles beyond the fetch latency.
2. id_stall held 6 cycles with BUF_DEPTH=2 → count saturates at 2, imem_req drops, pc_advance=0, id_pc holds. On release, entries drain in order without loss.
3. Redirect while in WAIT with rvalid 2 cycles later, new pc_in=0x100 → FSM enters DRAIN and the stale word is never visible. The first delivered id_pc is 0x100 and id_instr is NOP_INSTR until then.
4. Redirect and rvalid in the same cycle → response dropped, FSM returns to IDLE, the next request addr equals the redirected pc_in, and count=0.
5. Redirect and pop in the same cycle with count=2 → count=0 and id_valid=0 next cycle.
6. Assert reset while in WAIT → all outputs at reset values immediately (async), FSM=IDLE, and fetch restarts at pc_in=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 fetch-stage definitions: word width, canonical NOP, fetch FSM states, buffer entry.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bus: PC_Update handshake, instruction-memory port and IF/ID outputs.
interface if_fetch_queue_if;
  import riscv_pkg::*;

  logic [XLEN-1:0] pc_in;
  logic            redirect;
  logic            pc_advance;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            id_stall;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_instr;

  modport master (
    output pc_in, redirect, imem_gnt, imem_rvalid, imem_rdata, id_stall,
    input  pc_advance, imem_req, imem_addr, id_valid, id_pc, id_instr
  );

  modport slave (
    input  pc_in, redirect, imem_gnt, imem_rvalid, imem_rdata, id_stall,
    output pc_advance, imem_req, imem_addr, id_valid, id_pc, id_instr
  );

endinterface

// File: rtl/if_fifo.sv
// Circular instruction buffer with synchronous flush; flush overrides push and pop.
module if_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= AW'(wr_ptr + 1'b1);
      end
      if (pop) rd_ptr <= AW'(rd_ptr + 1'b1);
      count <= CW'(count + CW'(push) - CW'(pop));
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch: single-outstanding imem requests, stale-response drop after redirect, IF/ID buffer.
module if_fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned     BUF_DEPTH = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic             clk,
  input  logic             reset,
  if_fetch_queue_if.slave  bus
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] req_pc;
  logic [CW-1:0]   count;
  logic            req;
  logic            push;
  logic            pop;
  logic            valid;
  fetch_entry_t    head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, request and buffer write decisions.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    push      = 1'b0;
    unique case (state)
      IDLE: begin
        req = ~reset & ~bus.redirect & (count < CW'(BUF_DEPTH));
        if (req && bus.imem_gnt) state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          push      = ~bus.redirect;
          state_nxt = IDLE;
        end else if (bus.redirect) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.imem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The response carries no address, so the granted PC is held until it returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      req_pc <= '0;
    else if (req && bus.imem_gnt)   req_pc <= bus.pc_in;
  end

  assign valid = (count != '0);
  assign pop   = valid & ~bus.id_stall;

  if_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ('{pc: req_pc, instr: bus.imem_rdata}),
    .pop       (pop),
    .flush     (bus.redirect),
    .head      (head),
    .count     (count)
  );

  assign bus.imem_req   = req;
  assign bus.imem_addr  = bus.pc_in;
  assign bus.pc_advance = req & bus.imem_gnt;
  assign bus.id_valid   = valid;
  assign bus.id_pc      = valid ? head.pc : '0;
  assign bus.id_instr   = valid ? head.instr : NOP_INSTR;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized fetch-stage bench: behavioural memory + PC_Update driver, queue-based IF/ID reference.
module tb_if_fetch_queue;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  if_fetch_queue_if bus ();

  if_fetch_queue #(.BUF_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          checks   = 0;
  int          failures = 0;

  ent_t        q[$];
  logic [31:0] pc;
  bit          outstanding;
  bit          stale;
  int unsigned lat;
  logic [31:0] req_addr;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[31:2] ^ 30'h2A5A_5A5A, 2'b11};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(string ph);
    chk({ph, ":id_valid"}, 32'(bus.id_valid), 32'(q.size() != 0));
    chk({ph, ":id_pc"},    bus.id_pc,    (q.size() != 0) ? q[0].pc    : 32'h0);
    chk({ph, ":id_instr"}, bus.id_instr, (q.size() != 0) ? q[0].instr : NOP);
  endtask

  // One clock: drive random inputs, check request side, clock, update model, check IF/ID side.
  task automatic step(string ph, int unsigned p_gnt, int unsigned p_stall,
                      int unsigned p_redir, int unsigned lat_max);
    bit          redir, stall, gnt, rv, exp_req, accept;
    logic [31:0] target;
    redir  = ($urandom_range(99) < p_redir);
    stall  = ($urandom_range(99) < p_stall);
    gnt    = ($urandom_range(99) < p_gnt);
    target = 32'($urandom_range(0, 1023)) << 2;
    rv     = outstanding && (lat == 0);

    bus.pc_in       = pc;
    bus.redirect    = redir;
    bus.id_stall    = stall;
    bus.imem_gnt    = gnt;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? mem_word(req_addr) : $urandom;
    #1;
    exp_req = !outstanding && !redir && (q.size() < DEPTH);
    chk({ph, ":imem_req"},   32'(bus.imem_req),   32'(exp_req));
    chk({ph, ":pc_advance"}, 32'(bus.pc_advance), 32'(exp_req && gnt));
    if (exp_req) chk({ph, ":imem_addr"}, bus.imem_addr, pc);

    @(posedge clk);
    accept = 1'b0;
    if (exp_req && gnt) begin
      outstanding = 1'b1;
      stale       = 1'b0;
      req_addr    = pc;
      lat         = $urandom_range(0, lat_max);
    end else if (outstanding) begin
      if (rv) begin
        outstanding = 1'b0;
        accept      = !stale && !redir;
      end else begin
        if (redir) stale = 1'b1;
        lat--;
      end
    end
    if (redir) begin
      q.delete();
    end else begin
      if (q.size() != 0 && !stall) void'(q.pop_front());
      if (accept) q.push_back('{pc: req_addr, instr: mem_word(req_addr)});
    end
    if (redir)                pc = target;
    else if (exp_req && gnt)  pc = pc + 32'd4;
    #1;
    chk_outputs(ph);
  endtask

  initial begin
    bit reached;
    reset           = 1'b1;
    pc              = 32'h0;
    outstanding     = 1'b0;
    stale           = 1'b0;
    lat             = 0;
    req_addr        = 32'h0;
    bus.pc_in       = 32'h0;
    bus.redirect    = 1'b0;
    bus.id_stall    = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset:imem_req",   32'(bus.imem_req),   32'h0);
    chk("reset:pc_advance", 32'(bus.pc_advance), 32'h0);
    chk_outputs("reset");
    reset = 1'b0;

    // Streaming: always granted, single-cycle latency, no stall.
    repeat (20) step("stream", 100, 0, 0, 0);
    // Long decode stall fills the buffer, then release drains in order.
    repeat (8)  step("stall", 100, 100, 0, 0);
    repeat (8)  step("release", 100, 0, 0, 0);
    // Redirect-heavy with variable latency: DRAIN and redirect-on-response cases.
    repeat (400) step("redirect", 70, 30, 25, 2);
    // General mix.
    repeat (600) step("mix", 60, 40, 8, 3);

    // Asynchronous reset while a request is outstanding.
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      step("to_wait", 100, 0, 0, 3);
      reached = outstanding;
    end
    chk("reach_wait", 32'(reached), 32'h1);
    bus.redirect    = 1'b0;
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b0;
    reset           = 1'b1;
    #1;
    chk("async_rst:imem_req",   32'(bus.imem_req),   32'h0);
    chk("async_rst:pc_advance", 32'(bus.pc_advance), 32'h0);
    chk("async_rst:id_valid",   32'(bus.id_valid),   32'h0);
    chk("async_rst:id_pc",      bus.id_pc,           32'h0);
    chk("async_rst:id_instr",   bus.id_instr,        NOP);
    q.delete();
    outstanding = 1'b0;
    stale       = 1'b0;
    pc          = 32'h0;
    bus.pc_in   = 32'h0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (30) step("restart", 100, 10, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
